// File: rtl/bram_pkg.sv
// Shared sizing and word types for the 4K x 8 block RAM.
package bram_pkg;
  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
endpackage

// File: rtl/bram_array.sv
// Reset-free storage: synchronous write, combinational read of the addressed word.
module bram_array #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] o_rd
);

  // Power-up contents are all zero; nothing else ever clears the array.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock) begin
    if (wren) r_mem[address] <= data;
  end

  assign o_rd = r_mem[address];

endmodule

// File: rtl/bram_4kx8.sv
// Single-port RAM wrapper: clearable output register, read gating, write-through bypass.
module bram_4kx8
  import bram_pkg::*;
#(
  parameter int ADDR_WIDTH = bram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bram_pkg::DATA_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_nxt;
  logic [DATA_WIDTH-1:0] r_q;

  bram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clock  (clock),
    .address(address),
    .data   (data),
    .wren   (wren),
    .o_rd   (w_rd)
  );

  // Same-address read during a write returns the incoming data.
  assign w_nxt = wren ? data : w_rd;

  always_ff @(posedge clock or negedge aclr) begin
    if (!aclr)     r_q <= '0;
    else if (rden) r_q <= w_nxt;
  end

  assign q = r_q;

endmodule

// File: tb/tb_bram_4kx8.sv
// Directed plus randomized checks of bram_4kx8 against a plain array model.
module tb_bram_4kx8;
  import bram_pkg::*;

  logic  clock;
  logic  aclr;
  addr_t address;
  word_t data;
  logic  wren;
  logic  rden;
  word_t q;

  word_t ref_mem [DEPTH];
  word_t ref_q;
  int    checks;
  int    failures;

  bram_4kx8 dut (
    .clock  (clock),
    .aclr   (aclr),
    .address(address),
    .data   (data),
    .wren   (wren),
    .rden   (rden),
    .q      (q)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic chk(input word_t exp, input string tag);
    checks++;
    assert (q === exp) else begin
      failures++;
      $error("FAIL %s: q=%02h expected %02h", tag, q, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then update the model and compare.
  task automatic op(input logic w, input logic r, input int a, input int d, input string tag);
    word_t old;
    address = addr_t'(a);
    data    = word_t'(d);
    wren    = w;
    rden    = r;
    @(posedge clock);
    #1;
    old = ref_mem[a];
    if (w) ref_mem[a] = word_t'(d);
    if (r && aclr) ref_q = w ? word_t'(d) : old;
    if (!aclr) ref_q = '0;
    chk(ref_q, tag);
  endtask

  initial begin
    int a, d;
    logic w, r;
    checks = 0;
    failures = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_q   = '0;
    aclr    = 1'b1;
    wren    = 1'b0;
    rden    = 1'b0;
    address = '0;
    data    = '0;

    // Asynchronous reset pulse between clock edges.
    #5 aclr = 1'b0;
    #1 chk(8'h00, "reset_async");
    #2 aclr = 1'b1;
    op(0, 0, 0, 0, "idle_after_reset");

    op(1, 0, 15, 5, "wr15_a");
    op(1, 0, 15, 5, "wr15_b");
    op(0, 1, 15, 0, "rd15");
    op(0, 0, 0, 8'hFF, "hold_addr0");
    op(0, 0, 15, 8'hFF, "hold_addr15");
    op(0, 1, 0, 0, "rd_init0");

    op(1, 1, 100, 8'hA5, "wt100");
    op(0, 1, 15, 0, "rd15_between");
    op(0, 1, 100, 0, "rd100");

    op(1, 0, 4095, 8'h3C, "wr_top");
    op(1, 0, 0, 8'hC3, "wr_bot");
    op(0, 1, 4095, 0, "rd_top");
    op(0, 1, 0, 0, "rd_bot");

    op(1, 0, 7, 8'h11, "b2b_a");
    op(1, 0, 7, 8'h22, "b2b_b");
    op(0, 1, 7, 0, "b2b_rd");

    // Reset while q holds 5: clears q, ignores reads, keeps writing.
    op(0, 1, 15, 0, "pre_mid_rst");
    aclr = 1'b0;
    #2 chk(8'h00, "mid_rst_async");
    ref_q = '0;
    op(0, 1, 15, 0, "rd_in_rst");
    op(1, 1, 200, 8'h77, "wr_in_rst");
    aclr = 1'b1;
    op(0, 0, 15, 0, "post_rel_idle");
    op(0, 1, 15, 0, "post_rel_rd15");
    op(0, 1, 200, 0, "post_rel_rd200");

    // Random traffic over a small address pool plus the extremes to force collisions.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 0;
        1:       a = DEPTH - 1;
        default: a = int'($urandom_range(0, 15));
      endcase
      d = int'($urandom_range(0, 255));
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      aclr = ($urandom_range(0, 29) != 0);
      op(w, r, a, d, "rand");
    end
    aclr = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
